// File: rtl/qam_pkg.sv
// Shared QAM/convolutional-coding definitions: generator polynomials, tail length
// and the frame FSM encoding reused by the matching decoder.
package qam_pkg;

  localparam int SYM_LEN_DEF = 128;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int TAIL_LEN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } conv_state_t;

  // Returns {g0,g1} for input bit b with shift register sr (sr[1] newest).
  function automatic logic [1:0] conv_encode(input logic b, input logic [1:0] sr);
    logic [2:0] taps;
    taps = {b, sr};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_symbol_encoder_if.sv
// Bit-stream input and coded-dibit output bundle of the convolutional encoder.
interface conv_symbol_encoder_if;

  logic       data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] conv_out;
  logic       conv_active;
  logic       frame_done;
  logic       underrun;

  modport master (
    output data_in, data_valid,
    input  data_ready, conv_out, conv_active, frame_done, underrun
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, conv_out, conv_active, frame_done, underrun
  );

endinterface

// File: rtl/bit_fifo.sv
// Single-bit FIFO with full/empty flags; the head bit is presented from storage
// so a pop on the tick edge consumes the bit the encoder already sees.
module bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_symbol_encoder.sv
// Rate-1/2 K=3 convolutional encoder emitting one dibit per symbol period,
// framed as FRAME_LEN info bits plus two zero tail bits.
module conv_symbol_encoder
  import qam_pkg::*;
#(
  parameter int SYM_LEN    = SYM_LEN_DEF,
  parameter int FRAME_LEN  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  conv_symbol_encoder_if.slave bus
);

  localparam int SCW = $clog2(SYM_LEN);
  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam logic [SCW-1:0] SYM_LAST  = SCW'(SYM_LEN - 1);
  localparam logic [BCW-1:0] FRAME_CNT = BCW'(FRAME_LEN);

  conv_state_t    state;
  logic [SCW-1:0] sym_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [1:0]     sr;
  logic           tick;
  logic           fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           need_bit;
  logic           pop;
  logic           push;
  logic           next_bit;

  assign tick     = (sym_cnt == SYM_LAST);
  assign need_bit = (state == IDLE) || ((state == DATA) && (bit_cnt < FRAME_CNT));
  assign pop      = tick && need_bit && !fifo_empty;
  assign push     = bus.data_valid && !fifo_full;
  assign next_bit = fifo_empty ? 1'b0 : fifo_dout;

  assign bus.data_ready = !fifo_full;

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.data_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sym_cnt <= '0;
    else       sym_cnt <= tick ? '0 : sym_cnt + SCW'(1);
  end

  // Frame FSM; everything below advances only on the symbol tick so the new
  // dibit lands in the modulator's sampling cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sr              <= 2'b00;
      bit_cnt         <= '0;
      bus.conv_out    <= 2'b00;
      bus.conv_active <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.underrun    <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.underrun   <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!fifo_empty) begin
              bus.conv_out    <= conv_encode(fifo_dout, sr);
              sr              <= {fifo_dout, sr[1]};
              bus.conv_active <= 1'b1;
              bit_cnt         <= BCW'(1);
              state           <= DATA;
            end else begin
              bus.conv_out    <= 2'b00;
              bus.conv_active <= 1'b0;
            end
          end
          DATA: begin
            if (bit_cnt < FRAME_CNT) begin
              bus.conv_out <= conv_encode(next_bit, sr);
              sr           <= {next_bit, sr[1]};
              bus.underrun <= fifo_empty;
              bit_cnt      <= bit_cnt + BCW'(1);
            end else begin
              bus.conv_out <= conv_encode(1'b0, sr);
              sr           <= {1'b0, sr[1]};
              state        <= TAIL;
            end
          end
          TAIL: begin
            bus.conv_out   <= conv_encode(1'b0, sr);
            sr             <= {1'b0, sr[1]};
            bus.frame_done <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_symbol_encoder.sv
// Directed self-checking bench for conv_symbol_encoder (SYM_LEN=128, FRAME_LEN=4).
module tb_conv_symbol_encoder;

  localparam int SYM_LEN   = 128;
  localparam int FRAME_LEN = 4;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  conv_symbol_encoder_if bus ();

  conv_symbol_encoder #(
    .SYM_LEN    (SYM_LEN),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic next_symbol();
    do step(); while (cyc % SYM_LEN != 0);
  endtask

  task automatic apply_reset();
    bus.data_valid = 1'b0;
    bus.data_in    = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic apply_stimulus(input logic b);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic expect_symbol(input string tag, input logic [1:0] out, input logic act,
                               input logic done, input logic under);
    next_symbol();
    check_output({tag, ".out"},   8'(bus.conv_out),    8'(out));
    check_output({tag, ".act"},   8'(bus.conv_active), 8'(act));
    check_output({tag, ".done"},  8'(bus.frame_done),  8'(done));
    check_output({tag, ".under"}, 8'(bus.underrun),    8'(under));
  endtask

  initial begin
    logic [7:0] pat;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // Test 1: reset, idle for three symbols
    apply_reset();
    check_output("rst.out",   8'(bus.conv_out),    8'h0);
    check_output("rst.act",   8'(bus.conv_active), 8'h0);
    check_output("rst.done",  8'(bus.frame_done),  8'h0);
    check_output("rst.under", 8'(bus.underrun),    8'h0);
    check_output("rst.ready", 8'(bus.data_ready),  8'h1);
    repeat (3) expect_symbol("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Test 2: frame 1,0,1,1
    apply_reset();
    apply_stimulus(1'b1); apply_stimulus(1'b0); apply_stimulus(1'b1); apply_stimulus(1'b1);
    while (cyc < SYM_LEN - 1) step();
    check_output("f1.pre_tick", 8'(bus.conv_active), 8'h0);
    expect_symbol("f1.s0", 2'b11, 1'b1, 1'b0, 1'b0);
    expect_symbol("f1.s1", 2'b10, 1'b1, 1'b0, 1'b0);
    expect_symbol("f1.s2", 2'b00, 1'b1, 1'b0, 1'b0);
    expect_symbol("f1.s3", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("f1.t1", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("f1.t2", 2'b11, 1'b1, 1'b1, 1'b0);
    step();
    check_output("f1.done_pulse", 8'(bus.frame_done), 8'h0);
    expect_symbol("f1.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Test 3: nine back-to-back pushes into an 8-deep FIFO
    apply_reset();
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("fill.ready%0d", i), 8'(bus.data_ready), 8'h1);
      apply_stimulus(pat[i]);
    end
    check_output("fill.full", 8'(bus.data_ready), 8'h0);
    bus.data_in    = 1'b1;
    bus.data_valid = 1'b1;
    while (cyc < SYM_LEN - 1) step();
    check_output("fill.still_full", 8'(bus.data_ready), 8'h0);
    step();
    check_output("fill.after_pop", 8'(bus.data_ready), 8'h1);
    check_output("fill.s0", 8'(bus.conv_out), 8'h3);
    step();
    bus.data_valid = 1'b0;
    check_output("fill.refull", 8'(bus.data_ready), 8'h0);

    // Test 4: underrun after two bits
    apply_reset();
    apply_stimulus(1'b1); apply_stimulus(1'b1);
    expect_symbol("ur.s0", 2'b11, 1'b1, 1'b0, 1'b0);
    expect_symbol("ur.s1", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("ur.s2", 2'b01, 1'b1, 1'b0, 1'b1);
    step();
    check_output("ur.pulse", 8'(bus.underrun), 8'h0);
    expect_symbol("ur.s3", 2'b11, 1'b1, 1'b0, 1'b1);
    expect_symbol("ur.t1", 2'b00, 1'b1, 1'b0, 1'b0);
    expect_symbol("ur.t2", 2'b00, 1'b1, 1'b1, 1'b0);

    // Test 5: asynchronous reset mid-frame at clk 300
    apply_reset();
    apply_stimulus(1'b1); apply_stimulus(1'b0); apply_stimulus(1'b1); apply_stimulus(1'b1);
    while (cyc < 300) step();
    check_output("ar.mid_out", 8'(bus.conv_out),    8'h2);
    check_output("ar.mid_act", 8'(bus.conv_active), 8'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("ar.out",   8'(bus.conv_out),    8'h0);
    check_output("ar.act",   8'(bus.conv_active), 8'h0);
    check_output("ar.ready", 8'(bus.data_ready),  8'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    apply_stimulus(1'b1);
    while (cyc < SYM_LEN - 1) step();
    check_output("ar.restart_pre", 8'(bus.conv_active), 8'h0);
    step();
    check_output("ar.restart_out", 8'(bus.conv_out),    8'h3);
    check_output("ar.restart_act", 8'(bus.conv_active), 8'h1);

    // Test 6: back-to-back frames 1,0,1,1 then 1,1,0,0
    apply_reset();
    pat = 8'b0011_1101;
    for (int i = 0; i < 8; i++) apply_stimulus(pat[i]);
    expect_symbol("bb.a0", 2'b11, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.a1", 2'b10, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.a2", 2'b00, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.a3", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.at1", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.at2", 2'b11, 1'b1, 1'b1, 1'b0);
    expect_symbol("bb.b0", 2'b11, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.b1", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.b2", 2'b01, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.b3", 2'b11, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.bt1", 2'b00, 1'b1, 1'b0, 1'b0);
    expect_symbol("bb.bt2", 2'b00, 1'b1, 1'b1, 1'b0);
    expect_symbol("bb.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
